// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned NUM_TAPS_DEF    = 4;
  localparam int unsigned DEFAULT_DIV_DEF = 4;

  // Smallest divisor that still produces a clock; smaller requests are raised to this.
  localparam int unsigned MIN_DIV         = 2;

endpackage

// File: rtl/clk_div_taps.sv
// Free-running power-of-two divider: taps[i] is the enabled clock divided by 2^(i+1).
module clk_div_taps
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_TAPS = NUM_TAPS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [NUM_TAPS-1:0] taps
);

  logic [NUM_TAPS-1:0] r_cnt;

  // Binary counter; bit i toggles every 2^i enabled cycles, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + NUM_TAPS'(1);
    end
  end

  assign taps = r_cnt;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free divisor changes at period boundaries,
// plus a bank of fixed power-of-two taps.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned NUM_TAPS    = NUM_TAPS_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CNT_W-1:0]    div_val,
  input  logic                div_load,
  output logic                div_pending,
  output logic [CNT_W-1:0]    div_active,
  output logic                clk_out,
  output logic                tick,
  output logic [NUM_TAPS-1:0] taps
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_active;
  logic [CNT_W-1:0] r_pend_val;
  logic             r_pending;
  logic             r_clk_out;
  logic             r_tick;

  logic             w_wrap;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_div_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_half;
  logic             w_pending_next;

  // Next-period divisor selection, count advance and high-phase threshold.
  always_comb begin
    w_wrap         = 1'b0;
    w_load_val     = div_val;
    w_div_next     = r_div_active;
    w_cnt_next     = r_cnt;
    w_half         = '0;
    w_pending_next = r_pending;

    w_wrap = en && (r_cnt == r_div_active - CNT_W'(1));

    if (div_val < CNT_W'(MIN_DIV)) begin
      w_load_val = CNT_W'(MIN_DIV);
    end

    // A load on the wrap cycle bypasses the pending register entirely.
    if (w_wrap) begin
      w_cnt_next = '0;
      if (div_load) begin
        w_div_next = w_load_val;
      end else if (r_pending) begin
        w_div_next = r_pend_val;
      end
    end else if (en) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end

    if (div_load) begin
      w_pending_next = !w_wrap;
    end else if (w_wrap) begin
      w_pending_next = 1'b0;
    end

    // ceil(D/2) without needing an extra bit for D+1.
    w_half = (w_div_next >> 1) + CNT_W'(w_div_next[0]);
  end

  // Main counter, active divisor and registered outputs; all hold while en=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_div_active <= CNT_W'(DEFAULT_DIV);
      r_clk_out    <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (en) begin
        r_cnt        <= w_cnt_next;
        r_div_active <= w_div_next;
        r_clk_out    <= (w_cnt_next < w_half);
      end
    end
  end

  // Pending divisor capture, independent of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_val <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      if (div_load) begin
        r_pend_val <= w_load_val;
      end
    end
  end

  clk_div_taps #(
    .NUM_TAPS (NUM_TAPS)
  ) u_taps (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .taps (taps)
  );

  assign div_pending = r_pending;
  assign div_active  = r_div_active;
  assign clk_out     = r_clk_out;
  assign tick        = r_tick;

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Parameters
REQ-001 CNT_W, default 8, SHALL set the width of the divisor and of the main counter (legal range 2..16).
REQ-002 NUM_TAPS, default 4, SHALL set the number of fixed power-of-two divider taps (legal range 1..16).
REQ-003 DEFAULT_DIV, default 4, SHALL be the active divisor after reset (legal range 2..2^CNT_W-1).

Interface
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  count enable; when 0, all state and outputs hold.
REQ-007 div_val  in  CNT_W  requested divisor, sampled when div_load=1.
REQ-008 div_load  in  1  single-cycle request to load div_val.
REQ-009 div_pending  out  1  high while a loaded divisor awaits the next wrap.
REQ-010 div_active  out  CNT_W  divisor currently in effect.
REQ-011 clk_out  out  1  divided clock, registered.
REQ-012 tick  out  1  one-cycle pulse, registered, marking each wrap.
REQ-013 taps  out  NUM_TAPS  taps[i] is the input clock divided by 2^(i+1), registered.

Function
REQ-014 The main counter c SHALL advance only on cycles with en=1: if c==div_active-1 then c<=0 and tick<=1, else c<=c+1 and tick<=0.
REQ-015 On en=0 cycles, tick SHALL be driven 0; c, clk_out, taps, div_active and the pending divisor SHALL hold.
REQ-016 On each en=1 cycle, clk_out SHALL be registered as (c_next < ceil(D_next/2)), where c_next and D_next are the post-update count and divisor; the high phase is ceil(D/2) cycles per period.
REQ-017 div_load=1 SHALL capture div_val into a pending register and set div_pending=1 on the next edge, independent of en.
REQ-018 A pending divisor SHALL transfer to div_active only at a wrap (en=1 and c==div_active-1); div_pending clears on that edge; c restarts at 0. There is no mid-period change.
REQ-019 Repeated div_load before the wrap SHALL overwrite the pending value; the last value wins.
REQ-020 div_load on the same cycle as a wrap SHALL make the newly presented div_val active at that wrap; div_pending stays 0.
REQ-021 A captured div_val < 2 SHALL be clamped to 2.
REQ-022 A free-running NUM_TAPS-bit tap counter SHALL increment on every en=1 cycle, wrap modulo 2^NUM_TAPS, and be registered onto taps; it is unaffected by divisor loads.
REQ-023 With div_active=2, clk_out SHALL toggle every enabled cycle and tick SHALL pulse every second enabled cycle.

Reset
REQ-024 rst=1 SHALL immediately force: c=0, tap counter=0, div_active=DEFAULT_DIV, pending register=0, div_pending=0, clk_out=0, tick=0, taps=0.
REQ-025 Reset asserted mid-period or with a load pending SHALL discard the pending divisor; operation resumes from count 0 at DEFAULT_DIV on the first en=1 edge after release.

Structure
REQ-026 The package clk_div_pkg SHALL hold the CNT_W/NUM_TAPS/DEFAULT_DIV default constants and the MIN_DIV=2 constant.
REQ-027 The tap counter SHALL be one sub-module, clk_div_taps (ports clk, rst, en, taps), reusable stand-alone.
REQ-028 The design SHALL contain no derived-clock logic, no negedge logic and no latches; all outputs SHALL come directly from flops.

Verification
REQ-029 Reset release, en=1, no loads -> clk_out period 4 cycles with a 2-high/2-low pattern, tick every 4th cycle, taps[0..3] periods 2/4/8/16.
REQ-030 Load div_val=5 at count 1 -> div_pending=1 until the wrap; from the next period on, period=5 cycles, clk_out high 3 / low 2, div_active=5.
REQ-031 Loads of 7 then 3 within one period -> only 3 takes effect at the wrap; 7 is never active.
REQ-032 div_load with div_val=0 coincident with a wrap -> div_active=2 on that edge, div_pending never asserts.
REQ-033 en toggled 1,0,0,1 mid-period -> count and outputs frozen during the 0 cycles, tick=0 during the 0 cycles, period stretched by exactly 2 cycles.
REQ-034 rst pulse asynchronous to clk while a load is pending -> all outputs 0 immediately, div_active=4, and the pending value is lost.
